// File: rtl/fft_controller_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fft_controller_pkg : shared defaults, state encoding, bit reversal    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package fft_controller_pkg;

  localparam int c_N_LOG2_DEF     = 5;
  localparam int c_BF_LATENCY_DEF = 3;
  localparam int c_ADDR_W         = 5;
  localparam int c_TW_W           = 4;

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_LOAD         = 3'd1,
    S_COMPUTE      = 3'd2,
    S_DRAIN        = 3'd3,
    S_UNLOAD_ADDR  = 3'd4,
    S_UNLOAD_VALID = 3'd5
  } state_t;

  function automatic logic [4:0] bitrev5(input logic [4:0] a);
    return {a[0], a[1], a[2], a[3], a[4]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_controller_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fft_controller_if : handshake and FFT_DMEM control bundle             |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
interface fft_controller_if;
  import fft_controller_pkg::*;

  logic                start;
  logic                load_valid;
  logic                load_ready;
  logic                LoadEnable;
  logic                LoadDataWrite;
  logic [c_ADDR_W-1:0] LoadDataAddr;
  logic                RWAddrEN;
  logic                BankReadSelect;
  logic                Bank0WriteEN;
  logic                Bank1WriteEN;
  logic [c_ADDR_W-1:0] ReadGAddr;
  logic [c_ADDR_W-1:0] ReadHAddr;
  logic [c_ADDR_W-1:0] WriteGAddr;
  logic [c_ADDR_W-1:0] WriteHAddr;
  logic [c_TW_W-1:0]   TwiddleAddr;
  logic                out_valid;
  logic                out_ready;
  logic [c_ADDR_W-1:0] out_addr;
  logic                busy;
  logic                done;

  modport master (
    input  start, load_valid, out_ready,
    output load_ready, LoadEnable, LoadDataWrite, LoadDataAddr,
           RWAddrEN, BankReadSelect, Bank0WriteEN, Bank1WriteEN,
           ReadGAddr, ReadHAddr, WriteGAddr, WriteHAddr, TwiddleAddr,
           out_valid, out_addr, busy, done
  );

  modport slave (
    output start, load_valid, out_ready,
    input  load_ready, LoadEnable, LoadDataWrite, LoadDataAddr,
           RWAddrEN, BankReadSelect, Bank0WriteEN, Bank1WriteEN,
           ReadGAddr, ReadHAddr, WriteGAddr, WriteHAddr, TwiddleAddr,
           out_valid, out_addr, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/fft_bf_addr_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fft_bf_addr_gen : (stage, butterfly) -> G/H addresses and twiddle     |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module fft_bf_addr_gen
  import fft_controller_pkg::*;
(
  input  wire logic [2:0]          i_stage,
  input  wire logic [3:0]          i_bf,
  output logic      [c_ADDR_W-1:0] o_g,
  output logic      [c_ADDR_W-1:0] o_h,
  output logic      [c_TW_W-1:0]   o_tw
);

  logic [c_ADDR_W-1:0] w_half;
  logic [3:0]          w_mask;
  logic [3:0]          w_pos;

  // At stage 4 half is 16, whose low nibble is 0, so the mask wraps to 0xF.
  assign w_half = 5'd1 << i_stage;
  assign w_mask = w_half[3:0] - 4'd1;
  assign w_pos  = i_bf & w_mask;
  assign o_g    = ((({1'b0, i_bf}) >> i_stage) << (i_stage + 3'd1)) | {1'b0, w_pos};
  assign o_h    = o_g + w_half;
  assign o_tw   = w_pos << (3'd4 - i_stage);

endmodule
`default_nettype wire

// File: rtl/fft_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fft_controller : load / compute / unload sequencer for a 32-pt FFT    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module fft_controller
  import fft_controller_pkg::*;
#(
  parameter int N_LOG2     = c_N_LOG2_DEF,
  parameter int BF_LATENCY = c_BF_LATENCY_DEF
) (
  input wire logic          clock,
  input wire logic          reset,
  fft_controller_if.master  bus
);

  localparam logic [2:0]          c_LAST_STAGE = 3'(N_LOG2 - 1);
  localparam logic [3:0]          c_LAST_BF    = 4'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [c_ADDR_W-1:0] c_LAST_IDX   = c_ADDR_W'((1 << N_LOG2) - 1);
  localparam logic [3:0]          c_DRAIN_LAST = 4'(BF_LATENCY - 1);

  state_t              r_state, w_next;
  logic [c_ADDR_W-1:0] r_load_idx, r_out_idx;
  logic [2:0]          r_stage;
  logic [3:0]          r_bf, r_drain;
  logic                r_done;
  logic                w_issue;

  logic [BF_LATENCY-1:0] r_dl_vld, r_dl_tgt;
  logic [c_ADDR_W-1:0]   r_dl_g [BF_LATENCY];
  logic [c_ADDR_W-1:0]   r_dl_h [BF_LATENCY];

  logic [c_ADDR_W-1:0] w_g, w_h;
  logic [c_TW_W-1:0]   w_tw;

  fft_bf_addr_gen u_addr_gen (
    .i_stage (r_stage),
    .i_bf    (r_bf),
    .o_g     (w_g),
    .o_h     (w_h),
    .o_tw    (w_tw)
  );

  always_comb begin
    w_next             = r_state;
    w_issue            = 1'b0;
    bus.load_ready     = 1'b0;
    bus.LoadEnable     = 1'b0;
    bus.LoadDataWrite  = 1'b0;
    bus.LoadDataAddr   = '0;
    bus.RWAddrEN       = 1'b0;
    bus.BankReadSelect = 1'b0;
    bus.ReadGAddr      = '0;
    bus.ReadHAddr      = '0;
    bus.TwiddleAddr    = '0;
    bus.out_valid      = 1'b0;
    bus.out_addr       = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        bus.LoadEnable    = 1'b1;
        bus.load_ready    = 1'b1;
        bus.LoadDataWrite = bus.load_valid;
        bus.LoadDataAddr  = bitrev5(r_load_idx);
        if (bus.load_valid && r_load_idx == c_LAST_IDX) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        w_issue            = 1'b1;
        bus.BankReadSelect = r_stage[0];
        bus.RWAddrEN       = ~r_stage[0];
        bus.ReadGAddr      = w_g;
        bus.ReadHAddr      = w_h;
        bus.TwiddleAddr    = w_tw;
        if (r_bf == c_LAST_BF) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        bus.BankReadSelect = r_stage[0];
        bus.RWAddrEN       = ~r_stage[0];
        if (r_drain == c_DRAIN_LAST)
          w_next = (r_stage == c_LAST_STAGE) ? S_UNLOAD_ADDR : S_COMPUTE;
      end
      S_UNLOAD_ADDR: begin
        bus.BankReadSelect = 1'b1;
        bus.ReadGAddr      = r_out_idx;
        bus.out_addr       = r_out_idx;
        w_next             = S_UNLOAD_VALID;
      end
      S_UNLOAD_VALID: begin
        bus.BankReadSelect = 1'b1;
        bus.ReadGAddr      = r_out_idx;
        bus.out_addr       = r_out_idx;
        bus.out_valid      = 1'b1;
        if (bus.out_ready)
          w_next = (r_out_idx == c_LAST_IDX) ? S_IDLE : S_UNLOAD_ADDR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_load_idx <= '0;
      r_out_idx  <= '0;
      r_stage    <= '0;
      r_bf       <= '0;
      r_drain    <= '0;
      r_done     <= 1'b0;
      r_dl_vld   <= '0;
      r_dl_tgt   <= '0;
      for (int i = 0; i < BF_LATENCY; i++) begin
        r_dl_g[i] <= '0;
        r_dl_h[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_UNLOAD_VALID) && bus.out_ready && (r_out_idx == c_LAST_IDX);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_load_idx <= '0;
            r_out_idx  <= '0;
            r_stage    <= '0;
            r_bf       <= '0;
            r_drain    <= '0;
          end
        end
        S_LOAD:    if (bus.load_valid) r_load_idx <= r_load_idx + 1'b1;
        S_COMPUTE: begin
          r_bf    <= r_bf + 1'b1;
          r_drain <= '0;
        end
        S_DRAIN: begin
          r_drain <= r_drain + 1'b1;
          if (r_drain == c_DRAIN_LAST && r_stage != c_LAST_STAGE)
            r_stage <= r_stage + 1'b1;
        end
        S_UNLOAD_VALID: if (bus.out_ready) r_out_idx <= r_out_idx + 1'b1;
        default: ;
      endcase
      // Write-back pipe: matches the butterfly datapath latency.
      r_dl_vld[0] <= w_issue;
      r_dl_tgt[0] <= w_issue & ~r_stage[0];
      r_dl_g[0]   <= w_issue ? w_g : '0;
      r_dl_h[0]   <= w_issue ? w_h : '0;
      for (int i = 1; i < BF_LATENCY; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_tgt[i] <= r_dl_tgt[i-1];
        r_dl_g[i]   <= r_dl_g[i-1];
        r_dl_h[i]   <= r_dl_h[i-1];
      end
    end
  end

  assign bus.Bank1WriteEN = r_dl_vld[BF_LATENCY-1] &  r_dl_tgt[BF_LATENCY-1];
  assign bus.Bank0WriteEN = r_dl_vld[BF_LATENCY-1] & ~r_dl_tgt[BF_LATENCY-1];
  assign bus.WriteGAddr   = r_dl_g[BF_LATENCY-1];
  assign bus.WriteHAddr   = r_dl_h[BF_LATENCY-1];
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.done         = r_done;

endmodule
`default_nettype wire
